lsu_wb: RTL and testbench

Load/store and write-back unit: the consuming end of the issue stage's LSU and register-file-write request signals. It accepts one issued operation at a time, performs the memory transaction on the core data bus (req/gnt then rvalid), aligns and extends load data, and drives the single register-file write port with either the ALU result or the load result. It sits between issue/ALU and the register file, and it holds off issue through `ready_o` while a memory access is outstanding.

---
 rtl/lsu_wb.sv | 220 ++++++++++++++++++++++
 tb/tb_lsu_wb.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb.sv
// lsu_wb: load/store and write-back unit.
// Accepts one issued operation at a time, runs the req/gnt/rvalid data-bus
// transaction for loads and stores, aligns and extends load data and drives
// the single register-file write port.
// Optional feature macro: LSU_WB_ERR_EN (misaligned-access and bus-error
// reporting on err_o). When undefined, err_o is tied low and data_err_i is ignored.
module lsu_wb (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [1:0]  lsu_type_i,
  input  logic        lsu_sext_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [31:0] alu_result_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic        rf_soursel_i,
  input  logic        req_rf_w_i,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RVALID,
    S_WB
  } state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_data_req;
  logic        r_data_we;
  logic [3:0]  r_data_be;
  logic [31:0] r_data_addr;
  logic [31:0] r_data_wdata;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_rf_wdata;
  logic        r_err;

  // Operation context latched at accept
  logic        r_wb_en;
  logic        r_soursel;
  logic        r_sext;
  logic        r_is_load;
  logic [1:0]  r_type;
  logic [1:0]  r_off;
  logic [31:0] r_alu;
  logic [31:0] r_rdata;

  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_rdata_aligned;
  logic        w_misaligned;
  logic        w_bus_err;

  // Byte enables and replicated store data for the operation being issued
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    w_be    = 4'b1111;
    w_wdata = lsu_wdata_i;
    case (lsu_type_i)
      2'b01: begin
        w_be    = alu_result_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{lsu_wdata_i[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b0001 << alu_result_i[1:0];
        w_wdata = {4{lsu_wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

  // Shift the returned word down to the accessed byte lane, then extend
  always_comb begin
    w_shifted       = data_rdata_i >> {r_off, 3'b000};
    w_rdata_aligned = w_shifted;
    case (r_type)
      2'b01:   w_rdata_aligned = {{16{r_sext & w_shifted[15]}}, w_shifted[15:0]};
      2'b10:   w_rdata_aligned = {{24{r_sext & w_shifted[7]}}, w_shifted[7:0]};
      default: ;
    endcase
  end

`ifdef LSU_WB_ERR_EN
  // Misaligned half/word accesses are reported instead of issued
  always_comb begin
    w_misaligned = 1'b0;
    if (data_req_i) begin
      case (lsu_type_i)
        2'b01:   w_misaligned = alu_result_i[0];
        2'b10:   w_misaligned = 1'b0;
        default: w_misaligned = (alu_result_i[1:0] != 2'b00);
      endcase
    end
  end
  assign w_bus_err = data_err_i;
`else
  logic w_unused_err;
  assign w_unused_err = data_err_i;
  assign w_misaligned = 1'b0;
  assign w_bus_err    = 1'b0;
`endif

  // Control FSM; every output is a register updated here
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b1;
      r_data_req   <= 1'b0;
      r_data_we    <= 1'b0;
      r_data_be    <= 4'b0000;
      r_data_addr  <= 32'd0;
      r_data_wdata <= 32'd0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 5'd0;
      r_rf_wdata   <= 32'd0;
      r_err        <= 1'b0;
      r_wb_en      <= 1'b0;
      r_soursel    <= 1'b0;
      r_sext       <= 1'b0;
      r_is_load    <= 1'b0;
      r_type       <= 2'b00;
      r_off        <= 2'b00;
      r_alu        <= 32'd0;
      r_rdata      <= 32'd0;
    end else begin
      r_rf_we <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_ready    <= 1'b0;
            r_rf_waddr <= rf_waddr_i;
            r_wb_en    <= req_rf_w_i && (rf_waddr_i != 5'd0);
            r_soursel  <= rf_soursel_i;
            r_sext     <= lsu_sext_i;
            r_is_load  <= !data_we_i;
            r_type     <= lsu_type_i;
            r_off      <= alu_result_i[1:0];
            r_alu      <= alu_result_i;
            if (data_req_i && !w_misaligned) begin
              r_state      <= S_REQ;
              r_data_req   <= 1'b1;
              r_data_we    <= data_we_i;
              r_data_be    <= w_be;
              r_data_addr  <= {alu_result_i[31:2], 2'b00};
              r_data_wdata <= w_wdata;
            end else if (data_req_i) begin
              // Misaligned: skip the bus and report in the write-back slot
              r_state <= S_WB;
              r_err   <= 1'b1;
            end else begin
              r_state    <= S_WB;
              r_rf_we    <= req_rf_w_i && (rf_waddr_i != 5'd0);
              r_rf_wdata <= rf_soursel_i ? r_rdata : alu_result_i;
            end
          end
        end
        S_REQ: begin
          if (data_gnt_i) begin
            r_state    <= S_WAIT_RVALID;
            r_data_req <= 1'b0;
          end
        end
        S_WAIT_RVALID: begin
          if (data_rvalid_i) begin
            r_err <= w_bus_err;
            if (r_is_load) begin
              r_state    <= S_WB;
              r_rdata    <= w_rdata_aligned;
              r_rf_we    <= r_wb_en && !w_bus_err;
              r_rf_wdata <= r_soursel ? w_rdata_aligned : r_alu;
            end else begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end
          end
        end
        S_WB: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o      = r_ready;
  assign data_req_o   = r_data_req;
  assign data_we_o    = r_data_we;
  assign data_be_o    = r_data_be;
  assign data_addr_o  = r_data_addr;
  assign data_wdata_o = r_data_wdata;
  assign rf_we_o      = r_rf_we;
  assign rf_waddr_o   = r_rf_waddr;
  assign rf_wdata_o   = r_rf_wdata;
  assign err_o        = r_err;

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: transaction-level reference model,
// randomized operations and bus timing, plus directed boundary cases.
module tb_lsu_wb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [1:0]  lsu_type_i = 2'b00;
  logic        lsu_sext_i = 1'b0;
  logic [31:0] lsu_wdata_i = 32'd0;
  logic [31:0] alu_result_i = 32'd0;
  logic [4:0]  rf_waddr_i = 5'd0;
  logic        rf_soursel_i = 1'b0;
  logic        req_rf_w_i = 1'b0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic        data_err_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i = 32'd0;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        err_o;

  lsu_wb dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .lsu_type_i(lsu_type_i),
    .lsu_sext_i(lsu_sext_i), .lsu_wdata_i(lsu_wdata_i), .alu_result_i(alu_result_i),
    .rf_waddr_i(rf_waddr_i), .rf_soursel_i(rf_soursel_i), .req_rf_w_i(req_rf_w_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_err_i(data_err_i), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  typ;
    bit          sext;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [4:0]  rd;
    bit          soursel;
    bit          wreq;
    logic [31:0] rdata;
    bit          berr;
  } op_t;

  int n_checks = 0;
  int n_err = 0;

  // Expectations for the operation in flight
  bit          exp_req;
  logic [31:0] exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] exp_wdata;
  bit          exp_we;
  bit          exp_wb;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_rf_wdata;
  bit          exp_err;

  // Observations gathered by the monitor
  int          req_seen, wb_seen, err_seen;
  logic [31:0] last_addr, last_wdata, last_rf_wdata;
  logic [3:0]  last_be;
  logic [4:0]  last_rf_waddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_misaligned(input op_t op);
`ifdef LSU_WB_ERR_EN
    if (!op.is_mem) return 1'b0;
    if (op.typ == 2'b01) return op.addr[0];
    if (op.typ == 2'b10) return 1'b0;
    return op.addr[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] typ, input logic [31:0] addr);
    int off = int'(addr[1:0]);
    if (typ == 2'b01) return 4'((3 << (2 * (off / 2))) & 15);
    if (typ == 2'b10) return 4'((1 << off) & 15);
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] typ, input logic [31:0] w);
    if (typ == 2'b01) return {w[15:0], w[15:0]};
    if (typ == 2'b10) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] typ,
                                             input bit sext, input logic [31:0] addr);
    logic [31:0] s, mask, v;
    int bits;
    s = rdata >> (8 * int'(addr[1:0]));
    bits = (typ == 2'b01) ? 16 : (typ == 2'b10) ? 8 : 32;
    if (bits == 32) return s;
    mask = (32'd1 << bits) - 32'd1;
    v = s & mask;
    if (sext && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit model_berr(input op_t op);
`ifdef LSU_WB_ERR_EN
    return op.berr;
`else
    return 1'b0;
`endif
  endfunction

  // Set up expectations; returns accept-to-ready latency in cycles
  function automatic int set_expect(input op_t op, input int d, input int r);
    bit mis = model_misaligned(op);
    bit be_err = model_berr(op);
    exp_req      = op.is_mem && !mis;
    exp_addr     = {op.addr[31:2], 2'b00};
    exp_be       = model_be(op.typ, op.addr);
    exp_wdata    = model_wdata(op.typ, op.wdata);
    exp_we       = op.we;
    exp_waddr    = op.rd;
    exp_rf_wdata = op.soursel ? model_load(op.rdata, op.typ, op.sext, op.addr) : op.addr;
    exp_wb       = op.wreq && (op.rd != 5'd0) &&
                   (!op.is_mem || (!mis && !op.we && !be_err));
    exp_err      = mis || (exp_req && be_err);
    if (!exp_req) return 2;
    return op.we ? d + r + 3 : d + r + 4;
  endfunction

  // ---------------- monitor / compare ----------------
  always @(negedge clk_i) begin
    if (data_req_o) begin
      req_seen++;
      check("req_expected", 32'(data_req_o), 32'(exp_req));
      check("req_addr", data_addr_o, exp_addr);
      check("req_be", 32'(data_be_o), 32'(exp_be));
      check("req_wdata", data_wdata_o, exp_wdata);
      check("req_we", 32'(data_we_o), 32'(exp_we));
      last_addr  = data_addr_o;
      last_be    = data_be_o;
      last_wdata = data_wdata_o;
    end
    if (rf_we_o) begin
      wb_seen++;
      check("rf_waddr", 32'(rf_waddr_o), 32'(exp_waddr));
      check("rf_wdata", rf_wdata_o, exp_rf_wdata);
      last_rf_waddr = rf_waddr_o;
      last_rf_wdata = rf_wdata_o;
    end
    if (err_o) err_seen++;
  end

  // ---------------- driver / bus responder ----------------
  task automatic drive_op(input op_t op);
    valid_i      = 1'b1;
    data_req_i   = op.is_mem;
    data_we_i    = op.we;
    lsu_type_i   = op.typ;
    lsu_sext_i   = op.sext;
    lsu_wdata_i  = op.wdata;
    alu_result_i = op.addr;
    rf_waddr_i   = op.rd;
    rf_soursel_i = op.soursel;
    req_rf_w_i   = op.wreq;
  endtask

  task automatic scramble_inputs();
    valid_i      = 1'b0;
    data_req_i   = 1'($urandom);
    data_we_i    = 1'($urandom);
    lsu_type_i   = 2'($urandom);
    lsu_wdata_i  = $urandom;
    alu_result_i = $urandom;
    rf_waddr_i   = 5'($urandom);
    req_rf_w_i   = 1'($urandom);
  endtask

  task automatic run_op(input op_t op, input int d, input int r, input bit spur);
    int  lat, wait_g, wait_r, exp_lat;
    bit  granted, done;
    exp_lat = set_expect(op, d, r);
    req_seen = 0; wb_seen = 0; err_seen = 0;
    check("ready_before_op", 32'(ready_o), 32'd1);
    drive_op(op);
    @(posedge clk_i); #1;
    scramble_inputs();
    lat = 1; wait_g = 0; wait_r = 0; granted = 0; done = 0;
    while (!done && lat < 60) begin
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
      data_rdata_i = $urandom;
      if (ready_o) begin
        done = 1;
      end else begin
        if (!granted && data_req_o) begin
          if (wait_g == d) begin
            data_gnt_i = 1'b1;
            granted = 1;
          end else begin
            wait_g++;
            if (spur) begin data_rvalid_i = 1'b1; data_err_i = 1'($urandom); end
          end
        end else if (granted) begin
          if (wait_r == r) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = op.rdata;
            data_err_i    = op.berr;
          end else if (wait_r > r && spur) begin
            data_rvalid_i = 1'b1;
            data_err_i    = 1'($urandom);
          end
          wait_r++;
        end
        @(posedge clk_i); #1;
        lat++;
      end
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("req_cycles", 32'(req_seen), exp_req ? 32'(d + 1) : 32'd0);
    check("wb_count", 32'(wb_seen), 32'(exp_wb));
    check("err_count", 32'(err_seen), 32'(exp_err));
  endtask

  function automatic op_t mk_op(input bit is_mem, input bit we, input logic [1:0] typ,
                                input bit sext, input logic [31:0] wdata, input logic [31:0] addr,
                                input logic [4:0] rd, input bit soursel, input bit wreq,
                                input logic [31:0] rdata, input bit berr);
    op_t o;
    o.is_mem = is_mem; o.we = we; o.typ = typ; o.sext = sext; o.wdata = wdata;
    o.addr = addr; o.rd = rd; o.soursel = soursel; o.wreq = wreq; o.rdata = rdata; o.berr = berr;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.is_mem  = ($urandom_range(0, 2) != 0);
    o.we      = o.is_mem ? 1'($urandom) : 1'b0;
    o.typ     = 2'($urandom);
    o.sext    = 1'($urandom);
    o.wdata   = $urandom;
    o.addr    = $urandom;
    o.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    o.soursel = (o.is_mem && !o.we) ? ($urandom_range(0, 3) != 0) : 1'b0;
    o.wreq    = ($urandom_range(0, 4) != 0);
    o.rdata   = $urandom;
    o.berr    = ($urandom_range(0, 5) == 0);
    return o;
  endfunction

  initial begin
    op_t op;
    int  lat_dummy;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_req", 32'(data_req_o), 32'd0);
    check("rst_we", 32'(data_we_o), 32'd0);
    check("rst_be", 32'(data_be_o), 32'd0);
    check("rst_addr", data_addr_o, 32'd0);
    check("rst_wdata", data_wdata_o, 32'd0);
    check("rst_rf_we", 32'(rf_we_o), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr_o), 32'd0);
    check("rst_rf_wdata", rf_wdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Non-memory op
    run_op(mk_op(0, 0, 2'b00, 0, 32'd0, 32'h1234, 5'd5, 0, 1, 32'd0, 0), 0, 0, 0);
    check("tp_alu_waddr", 32'(last_rf_waddr), 32'd5);
    check("tp_alu_wdata", last_rf_wdata, 32'h0000_1234);

    // Signed then unsigned byte load at 0x103
    run_op(mk_op(1, 0, 2'b10, 1, 32'd0, 32'h103, 5'd7, 1, 1, 32'h80FF_0000, 0), 0, 0, 0);
    check("tp_lb_addr", last_addr, 32'h100);
    check("tp_lb_be", 32'(last_be), 32'h8);
    check("tp_lb_wdata", last_rf_wdata, 32'hFFFF_FF80);
    run_op(mk_op(1, 0, 2'b10, 0, 32'd0, 32'h103, 5'd7, 1, 1, 32'h80FF_0000, 0), 1, 2, 1);
    check("tp_lbu_wdata", last_rf_wdata, 32'h0000_0080);

    // Half store at 0x202, grant delayed three cycles
    run_op(mk_op(1, 1, 2'b01, 0, 32'hABCD_1234, 32'h202, 5'd9, 0, 1, 32'd0, 0), 3, 0, 1);
    check("tp_sh_req_cycles", 32'(req_seen), 32'd4);
    check("tp_sh_addr", last_addr, 32'h200);
    check("tp_sh_be", 32'(last_be), 32'hC);
    check("tp_sh_wdata", last_wdata, 32'h1234_1234);
    check("tp_sh_no_wb", 32'(wb_seen), 32'd0);

    // Load to x0: full transaction, no write
    run_op(mk_op(1, 0, 2'b00, 0, 32'd0, 32'h300, 5'd0, 1, 1, 32'h5555_AAAA, 0), 0, 1, 0);
    check("tp_x0_req", 32'(req_seen), 32'd1);
    check("tp_x0_no_wb", 32'(wb_seen), 32'd0);

    // Reset while waiting for rvalid; late rvalid must be ignored
    op = mk_op(1, 0, 2'b00, 0, 32'd0, 32'h40, 5'd3, 1, 1, 32'hDEAD_BEEF, 0);
    lat_dummy = set_expect(op, 0, 0);
    wb_seen = 0;
    drive_op(op);
    @(posedge clk_i); #1;
    scramble_inputs();
    data_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    data_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    data_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    check("rst_wait_ready", 32'(ready_o), 32'd1);
    check("rst_wait_no_wb", 32'(wb_seen), 32'd0);

    // Reset while requesting: request drops at that edge
    drive_op(op);
    @(posedge clk_i); #1;
    scramble_inputs();
    check("req_before_rst", 32'(data_req_o), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("rst_req_drop", 32'(data_req_o), 32'd0);
    check("rst_req_ready", 32'(ready_o), 32'd1);

`ifdef LSU_WB_ERR_EN
    run_op(mk_op(1, 0, 2'b00, 0, 32'd0, 32'h101, 5'd4, 1, 1, 32'd0, 0), 0, 0, 0);
    check("tp_mis_no_req", 32'(req_seen), 32'd0);
    check("tp_mis_err", 32'(err_seen), 32'd1);
    run_op(mk_op(1, 0, 2'b00, 0, 32'd0, 32'h100, 5'd4, 1, 1, 32'h1111_2222, 1), 0, 0, 0);
    check("tp_berr_err", 32'(err_seen), 32'd1);
    check("tp_berr_no_wb", 32'(wb_seen), 32'd0);
`endif

    // Randomized operations and bus timing
    for (int i = 0; i < 200; i++) begin
      run_op(rand_op(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
